// File: rtl/openofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit path: LTF sizing, sample format, FSM encoding.
package openofdm_tx_pkg;

   localparam int unsigned LTF_FFT_LEN = 64;
   localparam int unsigned SAMPLE_W    = 32;
   localparam int unsigned LTF_IDX_W   = $clog2(LTF_FFT_LEN);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      EMIT_CP,
      EMIT_SYM,
      DONE
   } ltf_state_e;

   // First buffer index that belongs to the cyclic prefix.
   function automatic logic [LTF_IDX_W-1:0] cp_start(input int unsigned cp_len);
      return LTF_IDX_W'(LTF_FFT_LEN - cp_len);
   endfunction

endpackage

// File: rtl/ltf_sample_ram.sv
// 64x32 simple dual-port sample store: one write port, one registered read port, no reset.
module ltf_sample_ram
   import openofdm_tx_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 wr_en_i,
   input  logic [LTF_IDX_W-1:0] wr_addr_i,
   input  logic [SAMPLE_W-1:0]  wr_data_i,
   input  logic                 rd_en_i,
   input  logic [LTF_IDX_W-1:0] rd_addr_i,
   output logic [SAMPLE_W-1:0]  rd_data_o
);

   logic [SAMPLE_W-1:0] mem [LTF_FFT_LEN];

   // Write port.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read; data holds when rd_en_i is low so a stalled output stays put.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_data_o <= mem[rd_addr_i];
      end
   end

endmodule

// File: rtl/ltf_time_assembler.sv
// Captures one 64-sample IFFT symbol and replays it as cyclic prefix + NUM_SYM bodies.
module ltf_time_assembler
   import openofdm_tx_pkg::*;
#(
   parameter int unsigned CP_LEN  = 32,
   parameter int unsigned NUM_SYM = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start_i,
   input  logic [SAMPLE_W-1:0] ifft_data_i,
   input  logic                ifft_valid_i,
   output logic                ifft_ready_o,
   output logic [SAMPLE_W-1:0] ltf_data_o,
   output logic                ltf_valid_o,
   input  logic                ltf_ready_i,
   output logic                busy_o,
   output logic                done_o
);

   localparam logic [LTF_IDX_W-1:0] IdxLast = LTF_IDX_W'(LTF_FFT_LEN - 1);
   localparam logic [LTF_IDX_W-1:0] CpStart = cp_start(CP_LEN);
   localparam logic [1:0]           SymLast = 2'(NUM_SYM - 1);

   ltf_state_e state_q, state_d;

   logic [LTF_IDX_W-1:0] wr_idx_q;
   logic [LTF_IDX_W-1:0] rd_idx_q;
   logic [1:0]           sym_cnt_q;
   logic                 last_issued_q;
   logic                 valid_q;
   logic [SAMPLE_W-1:0]  rd_data;

   logic cap_we;
   logic cap_last;
   logic advance;
   logic xfer;
   logic cp_issue;
   logic sym_issue;
   logic rd_en;

   // Handshake and read-issue decode; a read is issued only when the output slot frees up.
   always_comb begin
      advance   = !valid_q || ltf_ready_i;
      xfer      = valid_q && ltf_ready_i;
      cap_we    = (state_q == CAPTURE) && ifft_valid_i;
      cap_last  = cap_we && (wr_idx_q == IdxLast);
      cp_issue  = (state_q == EMIT_CP) && advance;
      sym_issue = (state_q == EMIT_SYM) && !last_issued_q && advance;
      rd_en     = cp_issue || sym_issue;
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; DONE is entered only once the final sample has actually transferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (start_i) state_d = CAPTURE;
         CAPTURE:  if (cap_last) state_d = EMIT_CP;
         EMIT_CP:  if (cp_issue && (rd_idx_q == IdxLast)) state_d = EMIT_SYM;
         EMIT_SYM: if (last_issued_q && xfer) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output decode; data is forced to zero whenever nothing valid is presented.
   always_comb begin
      ifft_ready_o = (state_q == CAPTURE);
      busy_o       = (state_q == CAPTURE) || (state_q == EMIT_CP) || (state_q == EMIT_SYM);
      done_o       = (state_q == DONE);
      ltf_valid_o  = valid_q;
      ltf_data_o   = valid_q ? rd_data : '0;
   end

   // Indices, symbol counter and output-valid pipeline stage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         sym_cnt_q     <= '0;
         last_issued_q <= 1'b0;
         valid_q       <= 1'b0;
      end else begin
         if ((state_q == IDLE) && start_i) begin
            wr_idx_q <= '0;
         end else if (cap_we) begin
            wr_idx_q <= wr_idx_q + 1'b1;
         end

         if (cap_last) begin
            rd_idx_q      <= CpStart;
            sym_cnt_q     <= '0;
            last_issued_q <= 1'b0;
         end else if (rd_en) begin
            // Index 63 wraps to 0, which is exactly where each body starts.
            rd_idx_q <= rd_idx_q + 1'b1;
            if (sym_issue && (rd_idx_q == IdxLast)) begin
               sym_cnt_q <= sym_cnt_q + 1'b1;
               if (sym_cnt_q == SymLast) begin
                  last_issued_q <= 1'b1;
               end
            end
         end

         if (advance) begin
            valid_q <= rd_en;
         end
      end
   end

   ltf_sample_ram u_ram (
      .clk_i     (clk),
      .wr_en_i   (cap_we),
      .wr_addr_i (wr_idx_q),
      .wr_data_i (ifft_data_i),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_idx_q),
      .rd_data_o (rd_data)
   );

endmodule

// File: tb/tb_ltf_time_assembler.sv
// Directed bench: default build, gapped capture, random backpressure, mid-build reset,
// ignored start/valid, and a short CP_LEN=16/NUM_SYM=1 variant.
module tb_ltf_time_assembler;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [31:0] ifft_data = '0;
   logic        ifft_valid = 1'b0;
   logic        ltf_ready = 1'b0;

   logic        iready_a, valid_a, busy_a, done_a;
   logic        iready_b, valid_b, busy_b, done_b;
   logic [31:0] data_a, data_b;

   logic        sel = 1'b0;
   logic        o_iready, o_valid, o_busy, o_done;
   logic [31:0] o_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ltf_time_assembler dut_a (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_a),
      .ifft_data_i  (ifft_data),
      .ifft_valid_i (ifft_valid),
      .ifft_ready_o (iready_a),
      .ltf_data_o   (data_a),
      .ltf_valid_o  (valid_a),
      .ltf_ready_i  (ltf_ready),
      .busy_o       (busy_a),
      .done_o       (done_a)
   );

   ltf_time_assembler #(.CP_LEN(16), .NUM_SYM(1)) dut_b (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_b),
      .ifft_data_i  (ifft_data),
      .ifft_valid_i (ifft_valid),
      .ifft_ready_o (iready_b),
      .ltf_data_o   (data_b),
      .ltf_valid_o  (valid_b),
      .ltf_ready_i  (ltf_ready),
      .busy_o       (busy_b),
      .done_o       (done_b)
   );

   assign o_iready = sel ? iready_b : iready_a;
   assign o_valid  = sel ? valid_b  : valid_a;
   assign o_busy   = sel ? busy_b   : busy_a;
   assign o_done   = sel ? done_b   : done_a;
   assign o_data   = sel ? data_b   : data_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   function automatic logic [31:0] expected(input int i, input int cp, input logic [31:0] seed);
      int e;
      e = (i < cp) ? (64 - cp + i) : ((i - cp) % 64);
      return seed + 32'(e);
   endfunction

   task automatic start_build();
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      check("busy_after_start", {31'd0, o_busy}, 32'd1);
      check("ready_in_capture", {31'd0, o_iready}, 32'd1);
   endtask

   // Feed 64 samples seed+k, inserting gap idle cycles before each one.
   task automatic capture(input logic [31:0] seed, input int gap, input bit junk);
      for (int k = 0; k < 64; k++) begin
         for (int g = 0; g < gap; g++) begin
            ifft_valid = 1'b0;
            ifft_data  = 32'hBAD0_0000;
            @(negedge clk);
         end
         ifft_valid = 1'b1;
         ifft_data  = seed + 32'(k);
         @(negedge clk);
      end
      check("ready_low_after_capture", {31'd0, o_iready}, 32'd0);
      check("valid_low_on_cp_entry", {31'd0, o_valid}, 32'd0);
      ifft_valid = junk;
      ifft_data  = 32'hDEAD_BEEF;
   endtask

   // Drain the build and check order, stall hold, count and done behaviour.
   task automatic collect(input int cp, input int nsym, input logic [31:0] seed, input bit rnd,
                          input int abort_at, input int poke_at);
      int   total;
      int   idx;
      bit   stall;
      bit   seen_done;
      logic r;
      logic [31:0] held;
      total     = cp + 64 * nsym;
      idx       = 0;
      stall     = 1'b0;
      seen_done = 1'b0;
      held      = '0;
      for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
         if (abort_at > 0 && idx == abort_at) return;
         if (stall) begin
            check("hold_valid", {31'd0, o_valid}, 32'd1);
            check("hold_data", o_data, held);
         end
         if (idx >= cp) ifft_valid = 1'b0;
         if (o_done) begin
            seen_done = 1'b1;
            check("count_at_done", 32'(idx), 32'(total));
            check("busy_low_at_done", {31'd0, o_busy}, 32'd0);
            check("valid_low_at_done", {31'd0, o_valid}, 32'd0);
            set_start(1'b1);
         end else begin
            set_start((poke_at > 0 && idx == poke_at) ? 1'b1 : 1'b0);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ltf_ready = r;
            if (o_valid && r) begin
               if (idx < total) check("sample", o_data, expected(idx, cp, seed));
               else check("extra_sample", 32'(idx), 32'(total - 1));
               idx++;
            end
            stall = o_valid && !r;
            held  = o_data;
         end
         @(negedge clk);
      end
      if (!seen_done) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         set_start(1'b0);
         check("done_one_cycle", {31'd0, o_done}, 32'd0);
         check("start_in_done_ignored", {31'd0, o_busy}, 32'd0);
         check("idle_ready_low", {31'd0, o_iready}, 32'd0);
      end
      ltf_ready = 1'b0;
   endtask

   initial begin
      bit saw_done;
      #1;
      check("rst_valid_a", {31'd0, valid_a}, 32'd0);
      check("rst_data_a", data_a, 32'd0);
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_done_a", {31'd0, done_a}, 32'd0);
      check("rst_iready_a", {31'd0, iready_a}, 32'd0);
      check("rst_busy_b", {31'd0, busy_b}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Default build, value = k.
      sel = 1'b0;
      start_build();
      capture(32'd0, 0, 1'b0);
      collect(32, 2, 32'd0, 1'b0, 0, 0);

      // Valid only one cycle in three during capture.
      start_build();
      capture(32'd0, 2, 1'b0);
      collect(32, 2, 32'd0, 1'b0, 0, 0);

      // Random backpressure with negative I components.
      start_build();
      capture(32'h8000_0000, 0, 1'b0);
      collect(32, 2, 32'h8000_0000, 1'b1, 0, 0);

      // Reset after 100 outputs.
      start_build();
      capture(32'h0000_7F00, 0, 1'b0);
      collect(32, 2, 32'h0000_7F00, 1'b0, 100, 0);
      rstn = 1'b0;
      #1;
      check("abort_valid", {31'd0, o_valid}, 32'd0);
      check("abort_data", o_data, 32'd0);
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      check("abort_iready", {31'd0, o_iready}, 32'd0);
      check("abort_done", {31'd0, o_done}, 32'd0);
      ltf_ready = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_done || o_busy || o_valid) saw_done = 1'b1;
      end
      check("no_activity_after_abort", {31'd0, saw_done}, 32'd0);
      start_build();
      capture(32'h1234_0000, 0, 1'b0);
      collect(32, 2, 32'h1234_0000, 1'b0, 0, 0);

      // start during EMIT_SYM and valid during EMIT_CP have no effect.
      start_build();
      capture(32'h0055_0000, 0, 1'b1);
      collect(32, 2, 32'h0055_0000, 1'b1, 0, 120);

      // CP_LEN=16, NUM_SYM=1 instance.
      sel = 1'b1;
      start_build();
      capture(32'd0, 0, 1'b0);
      collect(16, 1, 32'd0, 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ltf_time_assembler.md
LTF_TIME_ASSEMBLER -- requirements
Module: ltf_time_assembler

Interface
REQ-001 SHALL have parameter CP_LEN, default 32, cyclic-prefix length in samples, legal range 1..64.
REQ-002 SHALL have parameter NUM_SYM, default 2, count of repeated 64-sample LTF bodies, legal range 1..4.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse that arms a new LTF build.
REQ-006 SHALL have port ifft_data_i  input  32  IFFT output sample, {I[31:16], Q[15:0]}, two's complement.
REQ-007 SHALL have port ifft_valid_i  input  1  ifft_data_i is valid.
REQ-008 SHALL have port ifft_ready_o  output  1  block accepts an IFFT sample.
REQ-009 SHALL have port ltf_data_o  output  32  time-domain LTF sample, same format as ifft_data_i.
REQ-010 SHALL have port ltf_valid_o  output  1  ltf_data_o is valid.
REQ-011 SHALL have port ltf_ready_i  input  1  downstream accepts a sample.
REQ-012 SHALL have port busy_o  output  1  high from start accept until the last sample is transferred.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse after the final LTF sample transfers.

Function
REQ-014 SHALL use FSM states IDLE, CAPTURE, EMIT_CP, EMIT_SYM and DONE.
REQ-015 In IDLE, start_i SHALL move the FSM to CAPTURE, clear the write index and raise busy_o on the next cycle.
REQ-016 In CAPTURE, ifft_ready_o SHALL be 1, and each ifft_valid_i&&ifft_ready_o SHALL write the sample to buffer[wr_idx], then wr_idx++.
REQ-017 After the 64th capture, CAPTURE SHALL go to EMIT_CP with read index 64-CP_LEN; ifft_ready_o SHALL be 0 outside CAPTURE.
REQ-018 ltf_data_o SHALL be registered; ltf_valid_o SHALL rise no earlier than 1 cycle after state entry (1-cycle buffer read latency).
REQ-019 ltf_data_o and ltf_valid_o SHALL hold stable while ltf_valid_o=1 and ltf_ready_i=0.
REQ-020 Throughput SHALL be one sample per cycle while ltf_ready_i=1, with no bubbles at the CP/symbol or symbol/symbol boundaries.
REQ-021 EMIT_CP SHALL output buffer[64-CP_LEN..63] in order, then go to EMIT_SYM with read index 0.
REQ-022 EMIT_SYM SHALL output buffer[0..63] NUM_SYM times; the 6-bit read index SHALL wrap 63->0 and the symbol counter SHALL increment.
REQ-023 The total output per build SHALL be CP_LEN+64*NUM_SYM samples (160 at default).
REQ-024 After the final transfer, the FSM SHALL enter DONE, pulse done_o for exactly one cycle, drop busy_o in the same cycle, and return to IDLE.
REQ-025 start_i outside IDLE SHALL be ignored.
REQ-026 ifft_valid_i outside CAPTURE SHALL be ignored and the sample SHALL NOT be written.
REQ-027 A start_i asserted in the DONE cycle SHALL be ignored; start_i SHALL be accepted only in IDLE.
REQ-028 Sample values SHALL pass bit-exact; the block SHALL perform no arithmetic on samples.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE and clear all indices and counters.
REQ-030 rstn=0 SHALL force ifft_ready_o=0, ltf_valid_o=0, ltf_data_o=0, busy_o=0 and done_o=0.
REQ-031 Buffer contents SHALL NOT be reset; after reset, no stale sample SHALL be emitted.
REQ-032 Reset asserted mid-capture or mid-emit SHALL abort the build, and no done_o SHALL follow.

Structure
REQ-033 The shared openofdm_tx package SHALL hold the state enum, LTF_FFT_LEN=64 and the sample width 32.
REQ-034 The 64x32 storage SHALL be one sub-module, ltf_sample_ram: simple dual-port, 1 write and 1 registered read, no reset.

Verification
REQ-035 Default parameters, start, then 64 IFFT samples k (value=k) with ltf_ready_i=1 -> output 32..63, 0..63, 0..63; 160 samples; one done_o pulse.
REQ-036 ifft_valid_i toggled 1-of-3 cycles during CAPTURE -> capture order preserved; output identical to REQ-035.
REQ-037 ltf_ready_i random 50% -> no sample dropped or duplicated; data held stable during stalls, including across CP/symbol boundaries.
REQ-038 rstn pulsed low after 100 outputs -> outputs and busy_o are 0 immediately; no done_o; a new start gives a full correct 160-sample build.
REQ-039 CP_LEN=16, NUM_SYM=1 -> output 48..63, 0..63; 80 samples total.
REQ-040 start_i during EMIT_SYM and ifft_valid_i during EMIT_CP -> no effect on output sequence or buffer contents.
